// File: rtl/d_cache_pkg.sv
// Shared geometry, address-field helpers and FSM encoding for the direct-mapped
// write-through data cache.
package d_cache_pkg;
  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 4;

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_W   = WORD_SIZE - OFF_W - IDX_W;
  localparam int LINE_W  = WORD_SIZE * LINE_WORDS;
  localparam int IDX_LSB = OFF_W;
  localparam int TAG_LSB = OFF_W + IDX_W;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [LINE_W-1:0]    line_t;
  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [OFF_W-1:0]     off_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  function automatic off_t addr_off(input word_t a);
    return a[OFF_W-1:0];
  endfunction

  function automatic idx_t addr_idx(input word_t a);
    return a[TAG_LSB-1:IDX_LSB];
  endfunction

  function automatic tag_t addr_tag(input word_t a);
    return a[WORD_SIZE-1:TAG_LSB];
  endfunction

  // Performance counters stick at all-ones instead of wrapping.
  function automatic word_t sat_inc(input word_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/d_cache_if.sv
// CPU-side and memory-side signals of the data cache, bundled for port lists.
interface d_cache_if;
  import d_cache_pkg::*;

  // Requesters hold c_readM/c_writeM and operands stable until c_ready; the
  // cache holds m_readM/m_writeM and operands stable until m_ack.
  logic  c_readM;
  logic  c_writeM;
  word_t c_address;
  word_t c_wdata;
  word_t c_rdata;
  logic  c_ready;
  logic  m_readM;
  logic  m_writeM;
  word_t m_address;
  word_t m_wdata;
  line_t m_rdata;
  logic  m_ack;

  modport slave (
    input  c_readM, c_writeM, c_address, c_wdata, m_rdata, m_ack,
    output c_rdata, c_ready, m_readM, m_writeM, m_address, m_wdata
  );

  modport master (
    output c_readM, c_writeM, c_address, c_wdata, m_rdata, m_ack,
    input  c_rdata, c_ready, m_readM, m_writeM, m_address, m_wdata
  );
endinterface

// File: rtl/d_cache_array.sv
// Valid/tag/data storage: combinational read of one line, whole-line fill or
// single-word update on the clock; only the valid bits are reset.
module cache_array
  import d_cache_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  idx_t  rd_idx_i,
  output logic  rd_valid_o,
  output tag_t  rd_tag_o,
  output line_t rd_line_o,
  input  idx_t  wr_idx_i,
  input  logic  fill_en_i,
  input  tag_t  fill_tag_i,
  input  line_t fill_line_i,
  input  logic  word_en_i,
  input  off_t  wr_off_i,
  input  word_t wr_word_i
);
  logic [NUM_LINES-1:0] valid_q;
  tag_t                 tag_q  [NUM_LINES];
  line_t                data_q [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[wr_idx_i]  <= fill_tag_i;
      data_q[wr_idx_i] <= fill_line_i;
    end else if (word_en_i) begin
      data_q[wr_idx_i][int'(wr_off_i)*WORD_SIZE +: WORD_SIZE] <= wr_word_i;
    end
  end
endmodule

// File: rtl/d_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache: hit/miss FSM,
// memory strobes and saturating performance counters.
module d_cache
  import d_cache_pkg::*;
(
  input  logic      Clk,
  input  logic      Reset_N,
  d_cache_if.slave  bus,
  output word_t     hit_count,
  output word_t     miss_count,
  output state_e    state_o
);
  state_e state_q, state_d;
  word_t  addr_q, addr_d;
  word_t  wdata_q, wdata_d;
  word_t  hit_q, hit_d;
  word_t  miss_q, miss_d;
  logic   replay_q, replay_d;

  logic   rd_valid, lookup_hit, fill_en, word_en;
  tag_t   rd_tag;
  line_t  rd_line;
  word_t  rd_addr, rd_word;
  logic   ready, m_rd, m_wr;
  word_t  rdata, m_addr, m_wd;

  // Look up the live CPU address while idle, the latched one while busy.
  assign rd_addr    = (state_q == IDLE) ? bus.c_address : addr_q;
  assign lookup_hit = rd_valid && (rd_tag == addr_tag(rd_addr));
  assign rd_word    = rd_line[int'(addr_off(rd_addr))*WORD_SIZE +: WORD_SIZE];

  cache_array u_array (
    .clk_i       (Clk),
    .rst_n_i     (Reset_N),
    .rd_idx_i    (addr_idx(rd_addr)),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .wr_idx_i    (addr_idx(addr_q)),
    .fill_en_i   (fill_en),
    .fill_tag_i  (addr_tag(addr_q)),
    .fill_line_i (bus.m_rdata),
    .word_en_i   (word_en),
    .wr_off_i    (addr_off(addr_q)),
    .wr_word_i   (wdata_q)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    replay_d = 1'b0;
    ready    = 1'b0;
    rdata    = '0;
    m_rd     = 1'b0;
    m_wr     = 1'b0;
    m_addr   = '0;
    m_wd     = '0;
    fill_en  = 1'b0;
    word_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.c_writeM) begin
          addr_d  = bus.c_address;
          wdata_d = bus.c_wdata;
          state_d = WRITE;
          if (lookup_hit) hit_d = sat_inc(hit_q);
          else            miss_d = sat_inc(miss_q);
        end else if (bus.c_readM) begin
          if (lookup_hit) begin
            ready = 1'b1;
            rdata = rd_word;
            // The hit that completes a refilled read was already counted as a miss.
            if (!replay_q) hit_d = sat_inc(hit_q);
          end else begin
            miss_d  = sat_inc(miss_q);
            addr_d  = bus.c_address;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        m_rd   = 1'b1;
        m_addr = {addr_tag(addr_q), addr_idx(addr_q), {OFF_W{1'b0}}};
        if (bus.m_ack) begin
          fill_en  = 1'b1;
          replay_d = 1'b1;
          state_d  = IDLE;
        end
      end
      WRITE: begin
        m_wr   = 1'b1;
        m_addr = addr_q;
        m_wd   = wdata_q;
        if (bus.m_ack) begin
          ready   = 1'b1;
          word_en = lookup_hit;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      replay_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      replay_q <= replay_d;
    end
  end

  assign bus.c_ready   = ready;
  assign bus.c_rdata   = rdata;
  assign bus.m_readM   = m_rd;
  assign bus.m_writeM  = m_wr;
  assign bus.m_address = m_addr;
  assign bus.m_wdata   = m_wd;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_d_cache.sv
// Bench for d_cache: directed vectors, reset/stray-ack sequences and random
// accesses checked against a memory-image and tag-directory model.
module tb_d_cache;
  import d_cache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  d_cache_if bus();
  word_t  hit_count, miss_count;
  state_e dut_state;
  logic   resp_ack = 1'b0;
  logic   stray_ack = 1'b0;
  assign bus.m_ack = resp_ack | stray_ack;

  d_cache dut (
    .Clk        (clk),
    .Reset_N    (rst_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .state_o    (dut_state)
  );

  // ---------------- model state ----------------
  int    n_checks = 0;
  int    n_fail = 0;
  word_t phys_mem [int];
  word_t mdl_mem  [int];
  bit    mdl_valid [NUM_LINES];
  int    mdl_tag   [NUM_LINES];
  int    mdl_hits = 0;
  int    mdl_misses = 0;
  int    fixed_lat = 3;
  int    resp_cnt = 0;
  int    resp_lat = 1;
  logic [WORD_SIZE-1:0] exp_q[$];

  function automatic word_t init_val(input int a);
    return word_t'(a ^ 'hA5A5);
  endfunction

  function automatic word_t phys_rd(input int a);
    return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
  endfunction

  function automatic word_t mdl_rd(input int a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NUM_LINES; i++) mdl_valid[i] = 1'b0;
    mdl_hits = 0;
    mdl_misses = 0;
  endtask

  // ---------------- memory responder ----------------
  initial begin
    line_t line;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_ack) begin
        resp_ack = 1'b0;
        resp_cnt = 0;
      end else if (rst_n && (bus.m_readM || bus.m_writeM)) begin
        if (resp_cnt == 0) resp_lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
        resp_cnt++;
        if (resp_cnt >= resp_lat) begin
          resp_ack = 1'b1;
          if (bus.m_writeM) begin
            phys_mem[int'(bus.m_address)] = bus.m_wdata;
          end else begin
            for (int k = 0; k < LINE_WORDS; k++)
              line[k*WORD_SIZE +: WORD_SIZE] = phys_rd(int'(bus.m_address) + k);
            bus.m_rdata = line;
          end
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // ---------------- CPU driver ----------------
  // Starts just after a rising edge; returns just after the edge closing the access.
  task automatic cpu_access(input bit wr, input bit both, input word_t addr,
                            input word_t wd, output word_t rd);
    int  idx = int'(addr) / LINE_WORDS % NUM_LINES;
    int  tg = int'(addr) / (LINE_WORDS * NUM_LINES);
    bit  mhit = mdl_valid[idx] && (mdl_tag[idx] == tg);
    int  cyc = 0;
    int  exp_cyc;
    bit  done = 1'b0;
    word_t e;
    rd = '0;
    if (!wr) exp_q.push_back(mdl_rd(int'(addr)));
    if (mhit) mdl_hits++;
    else      mdl_misses++;
    if (!wr && !mhit) begin
      mdl_valid[idx] = 1'b1;
      mdl_tag[idx] = tg;
    end
    if (wr) mdl_mem[int'(addr)] = wd;

    bus.c_readM   = !wr || both;
    bus.c_writeM  = wr;
    bus.c_address = addr;
    bus.c_wdata   = wd;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (bus.m_readM || bus.m_writeM) begin
        check("strobe_excl", bus.m_readM & bus.m_writeM, 1'b0);
        check("strobe_kind", bus.m_writeM, wr);
        if (bus.m_readM) check("fill_addr", bus.m_address, {addr[15:2], 2'b00});
        if (bus.m_writeM) begin
          check("wr_addr", bus.m_address, addr);
          check("wr_data", bus.m_wdata, wd);
        end
      end
      if (bus.c_ready) begin
        done = 1'b1;
        rd = bus.c_rdata;
      end else begin
        cyc++;
      end
    end
    check("ready_seen", done, 1'b1);
    exp_cyc = wr ? resp_lat : (mhit ? 0 : resp_lat + 1);
    if (done) check("latency", cyc, exp_cyc);
    if (!wr) begin
      e = exp_q.pop_front();
      check("rdata", rd, e);
    end
    @(posedge clk); #1;
    bus.c_readM  = 1'b0;
    bus.c_writeM = 1'b0;
    check("hit_count", hit_count, mdl_hits);
    check("miss_count", miss_count, mdl_misses);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit    wr;
    word_t addr;
    word_t wd;
    word_t exp_rd;
    int    exp_hits;
    int    exp_misses;
  } vec_t;

  vec_t vecs [8];

  initial begin
    word_t rd;
    int    waited;
    bus.c_readM = 1'b0;
    bus.c_writeM = 1'b0;
    bus.c_address = '0;
    bus.c_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      phys_mem[16 + k] = word_t'(k + 1);
      mdl_mem[16 + k]  = word_t'(k + 1);
    end
    mdl_reset();

    vecs[0] = '{1'b0, 16'h0012, 16'h0000, 16'h0003, 0, 1};
    vecs[1] = '{1'b0, 16'h0013, 16'h0000, 16'h0004, 1, 1};
    vecs[2] = '{1'b1, 16'h0011, 16'hBEEF, 16'h0000, 2, 1};
    vecs[3] = '{1'b0, 16'h0011, 16'h0000, 16'hBEEF, 3, 1};
    vecs[4] = '{1'b1, 16'h0100, 16'h1234, 16'h0000, 3, 2};
    vecs[5] = '{1'b0, 16'h0010, 16'h0000, 16'h0001, 4, 2};
    vecs[6] = '{1'b0, 16'h0050, 16'h0000, 16'hA5F5, 4, 3};
    vecs[7] = '{1'b0, 16'h0012, 16'h0000, 16'h0003, 4, 4};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_c_ready", bus.c_ready, 1'b0);
    check("rst_c_rdata", bus.c_rdata, 16'h0000);
    check("rst_m_readM", bus.m_readM, 1'b0);
    check("rst_m_writeM", bus.m_writeM, 1'b0);
    check("rst_m_address", bus.m_address, 16'h0000);
    check("rst_m_wdata", bus.m_wdata, 16'h0000);
    check("rst_hits", hit_count, 16'h0000);
    check("rst_misses", miss_count, 16'h0000);
    check("rst_state", dut_state, IDLE);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fixed_lat = 3;
    for (int i = 0; i < 8; i++) begin
      cpu_access(vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].wd, rd);
      if (!vecs[i].wr) check($sformatf("tbl%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("tbl%0d_hits", i), hit_count, vecs[i].exp_hits);
      check($sformatf("tbl%0d_misses", i), miss_count, vecs[i].exp_misses);
    end

    // Reset in the middle of a line fill
    fixed_lat = 4;
    bus.c_readM = 1'b1;
    bus.c_address = 16'h0024;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.m_readM && waited < 10);
    check("midfill_strobe", bus.m_readM, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midfill_rd_drop", bus.m_readM, 1'b0);
    check("midfill_addr_drop", bus.m_address, 16'h0000);
    check("midfill_state", dut_state, IDLE);
    check("midfill_hits", hit_count, 16'h0000);
    check("midfill_misses", miss_count, 16'h0000);
    bus.c_readM = 1'b0;
    mdl_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_hits", hit_count, 16'h0000);
    check("post_rst_misses", miss_count, 16'h0000);
    cpu_access(1'b0, 1'b0, 16'h0012, 16'h0000, rd);
    check("post_rst_rdata", rd, 16'h0003);
    check("post_rst_miss1", miss_count, 16'h0001);
    check("post_rst_hit0", hit_count, 16'h0000);

    // Stray acknowledge with no request outstanding
    stray_ack = 1'b1;
    @(negedge clk);
    check("stray_ready", bus.c_ready, 1'b0);
    check("stray_strobes", {bus.m_readM, bus.m_writeM}, 2'b00);
    @(posedge clk); #1;
    stray_ack = 1'b0;
    check("stray_state", dut_state, IDLE);
    check("stray_hits", hit_count, mdl_hits);
    check("stray_misses", miss_count, mdl_misses);

    // Both strobes high behaves as a write to the hit line
    fixed_lat = 2;
    cpu_access(1'b1, 1'b1, 16'h0012, 16'h7777, rd);
    cpu_access(1'b0, 1'b0, 16'h0012, 16'h0000, rd);
    check("both_rdata", rd, 16'h7777);

    // Random traffic
    fixed_lat = 0;
    for (int n = 0; n < 300; n++) begin
      bit    w = ($urandom_range(0, 99) < 30);
      bit    b = w && ($urandom_range(0, 19) == 0);
      word_t a = word_t'($urandom_range(0, 47));
      word_t d = word_t'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        check("idle_ready", bus.c_ready, 1'b0);
        @(posedge clk); #1;
        check("idle_state", dut_state, IDLE);
      end
      cpu_access(w, b, a, d, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/d_cache.md
Name: d_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipelined CPU's data-memory port (d_readM/d_writeM/d_address/d_data) and a multi-cycle main memory.
- Turns each CPU access into a one-cycle hit or a stalled memory transaction, signalled by c_ready.
- Exposes hit and miss counters for performance reporting.

Parameters:
- WORD_SIZE, 16, data and address word width.
- LINE_WORDS, 4, words per line; power of 2.
- NUM_LINES, 4, number of lines; power of 2.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset_N  input  1  asynchronous active-low reset.
- c_readM  input  1  CPU read request.
- c_writeM  input  1  CPU write request.
- c_address  input  WORD_SIZE  CPU word address.
- c_wdata  input  WORD_SIZE  CPU write data.
- c_rdata  output  WORD_SIZE  read data; valid when c_ready=1 and c_readM=1.
- c_ready  output  1  access complete this cycle; CPU stalls while a request is pending and c_ready=0.
- m_readM  output  1  memory line-read request.
- m_writeM  output  1  memory word-write request.
- m_address  output  WORD_SIZE  memory address: line-aligned for reads, word address for writes.
- m_wdata  output  WORD_SIZE  memory write data.
- m_rdata  input  WORD_SIZE*LINE_WORDS  fill line; word k sits at bits [16k+15:16k].
- m_ack  input  1  memory transaction done; m_rdata is valid in the same cycle.
- hit_count  output  WORD_SIZE  accesses counted as hits.
- miss_count  output  WORD_SIZE  accesses counted as misses.

Behaviour:
- Address split: offset = low log2(LINE_WORDS) bits; index = next log2(NUM_LINES) bits; tag = remaining bits (12 at defaults). hit = valid[index] && tag[index]==addr tag.
- Reset (async, Reset_N=0):
  - all valid bits cleared; state=IDLE;
  - m_readM=m_writeM=0, m_address=0, m_wdata=0;
  - c_ready=0, c_rdata=0;
  - hit_count=miss_count=0;
  - data and tag arrays are not cleared.
- FSM states and transitions:
  - IDLE, read request, hit: c_ready=1 and c_rdata=line word at offset, combinationally in the same cycle; hit_count+1; stay IDLE.
  - IDLE, read request, miss: c_ready=0; miss_count+1; latch address; go FILL.
  - IDLE, write request: c_ready=0; latch address and data; count hit or miss; go WRITE.
  - FILL: m_readM=1, m_address={tag,index,0s}, held stable until m_ack. On m_ack: write the whole line, set tag, set valid; go IDLE. The next cycle re-evaluates the held request as a hit (read-miss latency = memory latency + 1 cycle).
  - WRITE: m_writeM=1, m_address and m_wdata = latched values, held until m_ack. On m_ack: c_ready=1; if the latched address hits, update that word in the line; go IDLE.
- Handshake rules:
  - The CPU holds its request stable until it sees c_ready.
  - A request present in the cycle after c_ready is a new access.
  - m_readM and m_writeM are never high together.
- Boundary conditions:
  - c_readM and c_writeM both high: illegal; write wins.
  - m_ack in IDLE: ignored.
  - A miss to a valid line overwrites it; no writeback, since the cache is write-through.
  - Counters saturate at 16'hFFFF.
  - Reset mid-FILL or mid-WRITE: transaction abandoned, strobes drop immediately, the line is not validated.
  - A request with neither strobe high: no state change, c_ready=0.

Decomposition:
- Shared include header d_cache_defs.v holds: state encodings (IDLE=2'd0, FILL=2'd1, WRITE=2'd2); offset/index/tag bit-position defines derived from the default parameters.
- One sub-module, cache_array: valid/tag/data storage with asynchronous read, synchronous line-fill write and word write, and async valid clear.
- FSM and counters stay in d_cache.

Test Plan:
- Reset, then read 0x0012 with memory returning line {4,3,2,1} after 3 cycles -> m_readM high with m_address=0x0010 until ack; next cycle c_ready=1, c_rdata=0x0003; miss_count=1.
- Reread 0x0013 after that fill -> c_ready=1 in the same cycle, c_rdata=0x0004, no memory strobe, hit_count=1.
- Write 0xBEEF to 0x0011 (hit) -> m_writeM=1, m_address=0x0011, m_wdata=0xBEEF until ack; c_ready on ack; a later read of 0x0011 hits with 0xBEEF.
- Write to 0x0100 (miss, index 0) -> memory written; line 0 tag unchanged; a read of 0x0010 still hits.
- Read 0x0050 (same index 0, new tag) -> refill evicts line 0; a following read of 0x0012 misses.
- Assert Reset_N=0 mid-FILL -> m_readM drops immediately; after release, a read of 0x0012 misses; both counters read 0.
